axi_wr_burst_slave: RTL and testbench

Parametrised AXI4 write-channel slave for the AXI-to-APB bridge front end. It accepts one AW burst at a time and generates per-beat addresses for FIXED, INCR and WRAP bursts. Each accepted W beat is pushed as {id, addr, strb, data, last} into the downstream command FIFO. It returns a B response with OKAY or SLVERR, and checks protocol legality (size, wrap length, WLAST alignment).

---
 rtl/axi_wr_burst_slave.sv | 104 ++++++++++
 tb/tb_axi_wr_burst_slave.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_burst_slave.sv
// axi_wr_burst_slave: single-outstanding AXI4 write slave that streams beats into a command FIFO.
// Illegal requests drain their beats silently; WLAST mismatches are reported but never truncate the burst.
module axi_wr_burst_slave #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    localparam int PL_W  = ID_W + ADDR_W + DATA_W / 8 + DATA_W + 1
) (
    input  logic                ACLK_i,
    input  logic                ARESETn_i,
    input  logic [ID_W-1:0]     AWID_i,
    input  logic [ADDR_W-1:0]   AWADDR_i,
    input  logic [7:0]          AWLEN_i,
    input  logic [2:0]          AWSIZE_i,
    input  logic [1:0]          AWBURST_i,
    input  logic                AWVALID_i,
    output logic                AWREADY_o,
    input  logic [DATA_W-1:0]   WDATA_i,
    input  logic [DATA_W/8-1:0] WSTRB_i,
    input  logic                WLAST_i,
    input  logic                WVALID_i,
    output logic                WREADY_o,
    output logic [ID_W-1:0]     BID_o,
    output logic [1:0]          BRESP_o,
    output logic                BVALID_o,
    input  logic                BREADY_i,
    output logic                fifo_wvld_o,
    input  logic                fifo_wrdy_i,
    output logic [PL_W-1:0]     fifo_wpayload_o
);
    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
    localparam logic [2:0] SZ_MAX = 3'($clog2(DATA_W / 8));
    localparam logic [ADDR_W-1:0] ONE = 1;
    state_t state_q, state_d;
    logic rst_done_q, aw_err_q, wl_err_q;
    logic [ID_W-1:0] id_q;
    logic [7:0] len_q, beat_cnt_q;
    logic [2:0] size_q;
    logic [1:0] burst_q;
    logic [ADDR_W-1:0] cur_addr_q, next_addr, nb, t, aw_nb;
    logic aw_hs, acc, last_beat, aw_err;
    assign aw_hs     = AWVALID_i & AWREADY_o;
    assign acc       = WVALID_i & WREADY_o;
    assign last_beat = beat_cnt_q == len_q;
    assign nb        = ONE << size_q;
    assign t         = nb * (ADDR_W'(len_q) + ONE);
    assign next_addr = (burst_q == 2'b00) ? cur_addr_q :
                       (burst_q == 2'b10) ? ((cur_addr_q & ~(t - ONE)) | ((cur_addr_q + nb) & (t - ONE))) :
                       (cur_addr_q & ~(nb - ONE)) + nb;
    assign aw_nb     = ONE << AWSIZE_i;
    assign aw_err    = (AWSIZE_i > SZ_MAX) | (AWBURST_i == 2'b11) |
                       ((AWBURST_i == 2'b10) & !(AWLEN_i inside {8'd1, 8'd3, 8'd7, 8'd15})) |
                       ((AWBURST_i == 2'b10) & (|(AWADDR_i & (aw_nb - ONE))));
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            state_q    <= IDLE;
            rst_done_q <= 1'b0;
            id_q       <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            cur_addr_q <= '0;
            beat_cnt_q <= '0;
            aw_err_q   <= 1'b0;
            wl_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
            if (aw_hs) begin
                id_q       <= AWID_i;
                len_q      <= AWLEN_i;
                size_q     <= AWSIZE_i;
                burst_q    <= AWBURST_i;
                cur_addr_q <= AWADDR_i;
                beat_cnt_q <= '0;
                aw_err_q   <= aw_err;
                wl_err_q   <= 1'b0;
            end
            if (acc) begin
                beat_cnt_q <= beat_cnt_q + 8'd1;
                cur_addr_q <= next_addr;
                if (WLAST_i != last_beat) wl_err_q <= 1'b1;
            end
            if (BVALID_o && BREADY_i) begin
                aw_err_q <= 1'b0;
                wl_err_q <= 1'b0;
            end
        end
    end
    always_comb begin
        state_d = (state_q == IDLE && aw_hs)            ? DATA :
                  (state_q == DATA && acc && last_beat) ? RESP :
                  (state_q == RESP && BREADY_i)         ? IDLE : state_q;
    end
    always_comb begin
        AWREADY_o       = (state_q == IDLE) & rst_done_q;
        WREADY_o        = (state_q == DATA) & (aw_err_q | fifo_wrdy_i);
        fifo_wvld_o     = (state_q == DATA) & ~aw_err_q & WVALID_i;
        BVALID_o        = state_q == RESP;
        BID_o           = (state_q == RESP) ? id_q : '0;
        BRESP_o         = ((state_q == RESP) && (aw_err_q || wl_err_q)) ? 2'b10 : 2'b00;
        fifo_wpayload_o = {id_q, cur_addr_q, WSTRB_i, WDATA_i, last_beat};
    end
endmodule

// File: tb/tb_axi_wr_burst_slave.sv
// tb_axi_wr_burst_slave: directed plus randomized bursts scored against a queue-based reference model.
module tb_axi_wr_burst_slave;
    localparam int ID_W = 4, ADDR_W = 12, DATA_W = 32, PL_W = 53, TMO = 200;
    logic clk = 1'b0, ARESETn_i = 1'b0;
    logic [ID_W-1:0] AWID_i = '0, BID_o;
    logic [ADDR_W-1:0] AWADDR_i = '0;
    logic [7:0] AWLEN_i = '0;
    logic [2:0] AWSIZE_i = '0;
    logic [1:0] AWBURST_i = '0, BRESP_o;
    logic AWVALID_i = 1'b0, AWREADY_o, WLAST_i = 1'b0, WVALID_i = 1'b0, WREADY_o;
    logic [DATA_W-1:0] WDATA_i = '0;
    logic [DATA_W/8-1:0] WSTRB_i = '0;
    logic BVALID_o, BREADY_i = 1'b0, fifo_wvld_o, fifo_wrdy_i = 1'b1;
    logic [PL_W-1:0] fifo_wpayload_o;
    int checks = 0, fails = 0;
    bit rand_bp = 1'b0;
    logic [PL_W-1:0] exp_pl[$];
    logic [5:0] exp_b[$];

    always #5 clk = ~clk;

    axi_wr_burst_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ACLK_i(clk), .ARESETn_i(ARESETn_i),
        .AWID_i(AWID_i), .AWADDR_i(AWADDR_i), .AWLEN_i(AWLEN_i), .AWSIZE_i(AWSIZE_i),
        .AWBURST_i(AWBURST_i), .AWVALID_i(AWVALID_i), .AWREADY_o(AWREADY_o),
        .WDATA_i(WDATA_i), .WSTRB_i(WSTRB_i), .WLAST_i(WLAST_i), .WVALID_i(WVALID_i), .WREADY_o(WREADY_o),
        .BID_o(BID_o), .BRESP_o(BRESP_o), .BVALID_o(BVALID_o), .BREADY_i(BREADY_i),
        .fifo_wvld_o(fifo_wvld_o), .fifo_wrdy_i(fifo_wrdy_i), .fifo_wpayload_o(fifo_wpayload_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        checks++;
        fails++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bp();
        if (rand_bp) fifo_wrdy_i = ($urandom_range(0, 3) != 0);
    endtask

    // Address of beat k, straight from the burst definitions rather than a running update.
    function automatic logic [ADDR_W-1:0] exp_addr(input int start, input int k, input int size, input int len, input int bt);
        int nb = 1 << size;
        int t = nb * (len + 1);
        if (bt == 0) return ADDR_W'(start);
        if (bt == 1) return ADDR_W'((k == 0) ? start : ((start / nb) * nb + k * nb) % 4096);
        return ADDR_W'((start / t) * t + (start % t + k * nb) % t);
    endfunction

    function automatic bit aw_bad(input int addr, input int len, input int size, input int bt);
        return size > 2 || bt == 3 || (bt == 2 && !(len inside {1, 3, 7, 15})) || (bt == 2 && addr % (1 << size) != 0);
    endfunction

    task automatic check_reset_outs(input string tag);
        chk({tag, "_awready"}, 64'(AWREADY_o), 0);
        chk({tag, "_wready"}, 64'(WREADY_o), 0);
        chk({tag, "_bvalid"}, 64'(BVALID_o), 0);
        chk({tag, "_bresp"}, 64'(BRESP_o), 0);
        chk({tag, "_bid"}, 64'(BID_o), 0);
        chk({tag, "_fifo_wvld"}, 64'(fifo_wvld_o), 0);
    endtask

    task automatic burst(input int id, input int addr, input int len, input int size, input int bt,
                         input int bad_wl, input int stall_k, input int abort_k);
        bit ae = aw_bad(addr, len, size, bt);
        bit we = 1'b0;
        bit hs;
        int n;
        AWID_i = ID_W'(id);
        AWADDR_i = ADDR_W'(addr);
        AWLEN_i = 8'(len);
        AWSIZE_i = 3'(size);
        AWBURST_i = 2'(bt);
        AWVALID_i = 1'b1;
        hs = 1'b0;
        n = 0;
        while (!hs) begin
            @(negedge clk);
            hs = AWREADY_o;
            tick();
            if (!hs && ++n > TMO) begin
                expire("aw_handshake");
                AWVALID_i = 1'b0;
                return;
            end
        end
        AWVALID_i = 1'b0;
        for (int k = 0; k <= len; k++) begin
            if (k == abort_k) begin
                WVALID_i = 1'b0;
                #2 ARESETn_i = 1'b0;
                #1 check_reset_outs("mid_reset");
                exp_pl.delete();
                tick();
                tick();
                ARESETn_i = 1'b1;
                @(negedge clk);
                chk("awready_before_first_edge", 64'(AWREADY_o), 0);
                tick();
                chk("awready_after_release", 64'(AWREADY_o), 1);
                return;
            end
            WDATA_i = $urandom;
            WSTRB_i = DATA_W'($urandom) >> (DATA_W - DATA_W / 8);
            WLAST_i = (k == len) ^ (k == bad_wl);
            if (k == bad_wl) we = 1'b1;
            if (!ae) exp_pl.push_back({ID_W'(id), exp_addr(addr, k, size, len, bt), WSTRB_i, WDATA_i, k == len});
            WVALID_i = 1'b1;
            if (k == stall_k) begin
                fifo_wrdy_i = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_wready", 64'(WREADY_o), 0);
                    tick();
                end
                fifo_wrdy_i = 1'b1;
            end else bp();
            hs = 1'b0;
            n = 0;
            while (!hs) begin
                @(negedge clk);
                hs = WREADY_o;
                tick();
                if (!hs) begin
                    bp();
                    if (++n > TMO) begin
                        expire("w_handshake");
                        WVALID_i = 1'b0;
                        return;
                    end
                end
            end
        end
        WVALID_i = 1'b0;
        WLAST_i = 1'b0;
        fifo_wrdy_i = 1'b1;
        exp_b.push_back({ID_W'(id), (ae || we) ? 2'b10 : 2'b00});
        repeat ($urandom_range(0, 3)) tick();
        BREADY_i = 1'b1;
        hs = 1'b0;
        n = 0;
        while (!hs) begin
            @(negedge clk);
            hs = BVALID_o;
            tick();
            if (!hs && ++n > TMO) begin
                expire("b_handshake");
                break;
            end
        end
        BREADY_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ARESETn_i) begin
            if (fifo_wvld_o && fifo_wrdy_i) begin
                if (exp_pl.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL fifo_unexpected actual=%0h required=none", fifo_wpayload_o);
                end else chk("fifo_payload", 64'(fifo_wpayload_o), 64'(exp_pl.pop_front()));
            end
            if (BVALID_o && BREADY_i) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL b_unexpected actual=%0h required=none", {BID_o, BRESP_o});
                end else chk("b_id_resp", 64'({BID_o, BRESP_o}), 64'(exp_b.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        tick();
        ARESETn_i = 1'b1;
        @(negedge clk);
        chk("awready_first_cycle", 64'(AWREADY_o), 0);
        tick();
        chk("awready_ready", 64'(AWREADY_o), 1);
        WVALID_i = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_wready", 64'(WREADY_o), 0);
            tick();
        end
        WVALID_i = 1'b0;
        burst(5, 'h104, 3, 2, 1, -1, -1, -1);
        burst(6, 'h038, 3, 2, 2, -1, -1, -1);
        burst(7, 'h200, 2, 2, 0, -1, 1, -1);
        burst(8, 'h100, 1, 3, 1, -1, -1, -1);
        burst(9, 'h000, 3, 2, 1, 0, -1, -1);
        burst(10, 'h300, 7, 2, 1, -1, -1, 2);
        burst(11, 'h040, 7, 2, 1, -1, -1, -1);
        burst(12, 'hFF8, 3, 2, 1, -1, -1, -1);
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int bt, size, len, addr, bad;
            bt = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
            size = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            len = (bt == 2) ? (($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : (2 << $urandom_range(0, 3)) - 1)
                            : $urandom_range(0, 15);
            addr = $urandom_range(0, 4095);
            if (bt == 2 && $urandom_range(0, 3) != 0) addr = addr & ~((1 << size) - 1);
            bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
            burst($urandom_range(0, 15), addr, len, size, bt, bad, -1, -1);
        end
        rand_bp = 1'b0;
        fifo_wrdy_i = 1'b1;
        repeat (5) tick();
        chk("payload_queue_empty", 64'(exp_pl.size()), 0);
        chk("b_queue_empty", 64'(exp_b.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
